// File: rtl/slice_sequencer_pkg.sv
// Shared definitions for the slice sequencer and the Mapper bench.
// Holds the default slice geometry (N x M bits), the number of slices per
// pass with the matching address width, and the 2-bit FSM state encoding.
`timescale 1ns/1ps

package slice_sequencer_pkg;

    localparam int DefaultN          = 5;
    localparam int DefaultM          = 5;
    localparam int DefaultSliceCount = 64;
    localparam int DefaultAddrWidth  = 6;

    // The pipeline holds two slices after the last read has been issued
    localparam int DrainCycles = 2;

    localparam logic [1:0] StateIdle  = 2'd0;
    localparam logic [1:0] StateRead  = 2'd1;
    localparam logic [1:0] StateDrain = 2'd2;
    localparam logic [1:0] StateDone  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = StateIdle,
        READ  = StateRead,
        DRAIN = StateDrain,
        DONE  = StateDone
    } seqState_t;

endpackage

// File: rtl/slice_pipe_reg.sv
// One register stage of the slice pipeline: a valid bit plus a payload
// (address, or address and slice data packed together).
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   validIn      valid bit entering the stage
//   payloadIn    payload entering the stage
//   validOut     registered valid bit, cleared by reset
//   payloadOut   registered payload, cleared by reset
`timescale 1ns/1ps

module slice_pipe_reg #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validIn,
    input  logic [Width-1:0] payloadIn,
    output logic             validOut,
    output logic [Width-1:0] payloadOut
);

    // The payload is loaded every cycle; downstream only trusts it while
    // validOut is high, so there is no need to gate the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validOut   <= 1'b0;
            payloadOut <= '0;
        end else begin
            validOut   <= validIn;
            payloadOut <= payloadIn;
        end
    end

endmodule

// File: rtl/slice_sequencer.sv
// Sequencer around the combinational slice permutation (Mapper).
// On start it reads SliceCount slices from a synchronous source memory,
// one per cycle, registers each into the Mapper, and writes the permuted
// slice to the destination memory at the same address. A one-cycle done
// pulse follows the last write.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   start, ready, done  pass handshake (start only honoured in IDLE)
//   rd_en, rd_addr      source memory read request
//   rd_data             source data, one cycle after rd_en
//   map_in, map_out     registered slice to / permuted slice from Mapper
//   wr_en, wr_addr      destination write request
//   wr_data             permuted slice to write
`timescale 1ns/1ps

module slice_sequencer
    import slice_sequencer_pkg::*;
#(
    parameter int N          = DefaultN,
    parameter int M          = DefaultM,
    parameter int SliceCount = DefaultSliceCount,
    parameter int AddrWidth  = DefaultAddrWidth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ready,
    output logic                 done,
    output logic                 rd_en,
    output logic [AddrWidth-1:0] rd_addr,
    input  logic [N*M-1:0]       rd_data,
    output logic [N*M-1:0]       map_in,
    input  logic [N*M-1:0]       map_out,
    output logic                 wr_en,
    output logic [AddrWidth-1:0] wr_addr,
    output logic [N*M-1:0]       wr_data
);

    localparam int SliceBits = N * M;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(SliceCount - 1);

    seqState_t            state;
    seqState_t            stateNext;
    logic [AddrWidth-1:0] readCnt;
    logic [AddrWidth-1:0] readCntNext;
    logic                 drainCnt;
    logic                 drainCntNext;

    logic                           v1;
    logic [AddrWidth-1:0]           a1;
    logic                           v2;
    logic [AddrWidth+SliceBits-1:0] stage3Out;

    // State, read address counter and drain counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            readCnt  <= '0;
            drainCnt <= 1'b0;
        end else begin
            state    <= stateNext;
            readCnt  <= readCntNext;
            drainCnt <= drainCntNext;
        end
    end

    // Next-state and control outputs. The read counter saturates at the
    // last address so nothing outside the slice range is ever issued.
    always_comb begin
        stateNext    = state;
        readCntNext  = readCnt;
        drainCntNext = drainCnt;
        ready        = 1'b0;
        rd_en        = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                ready       = 1'b1;
                readCntNext = '0;
                if (start) begin
                    stateNext = READ;
                end
            end
            READ: begin
                rd_en = 1'b1;
                if (readCnt == LastAddr) begin
                    stateNext    = DRAIN;
                    drainCntNext = 1'b0;
                end else begin
                    readCntNext = readCnt + 1'b1;
                end
            end
            DRAIN: begin
                if (drainCnt == 1'(DrainCycles - 1)) begin
                    stateNext = DONE;
                end else begin
                    drainCntNext = drainCnt + 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign rd_addr = readCnt;

    // Stage 2: the read request travels alongside the memory latency so
    // v1/a1 line up with rd_data.
    slice_pipe_reg #(
        .Width(AddrWidth)
    ) stage2 (
        .clk       (clk),
        .rst       (rst),
        .validIn   (rd_en),
        .payloadIn (rd_addr),
        .validOut  (v1),
        .payloadOut(a1)
    );

    // Stage 3: captures the returned slice together with its address;
    // the low part of the payload is the slice register feeding the Mapper.
    slice_pipe_reg #(
        .Width(AddrWidth + SliceBits)
    ) stage3 (
        .clk       (clk),
        .rst       (rst),
        .validIn   (v1),
        .payloadIn ({a1, rd_data}),
        .validOut  (v2),
        .payloadOut(stage3Out)
    );

    assign map_in  = stage3Out[SliceBits-1:0];
    assign wr_en   = v2;
    assign wr_addr = stage3Out[AddrWidth+SliceBits-1:SliceBits];
    assign wr_data = map_out;

endmodule

// File: tb/tb_slice_sequencer.sv
// Bench for slice_sequencer with a behavioural slice permutation (pi step
// on a 5x5 slice, centred on bit 12) standing in for the Mapper, and
// behavioural source/destination memories.
`timescale 1ns/1ps

module tb_slice_sequencer;

    localparam int N          = 5;
    localparam int M          = 5;
    localparam int SliceCount = 64;
    localparam int AddrWidth  = 6;
    localparam int W          = N * M;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 ready;
    logic                 done;
    logic                 rd_en;
    logic [AddrWidth-1:0] rd_addr;
    logic [W-1:0]         rd_data;
    logic [W-1:0]         map_in;
    logic [W-1:0]         map_out;
    logic                 wr_en;
    logic [AddrWidth-1:0] wr_addr;
    logic [W-1:0]         wr_data;

    slice_sequencer #(
        .N(N), .M(M), .SliceCount(SliceCount), .AddrWidth(AddrWidth)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .map_in(map_in), .map_out(map_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // Slice permutation: centred coordinates x=c-2, y=r-2 map to
    // (y, 2x+3y) mod 5; bit index is 5*r + c.
    function automatic logic [W-1:0] mapSlice(input logic [W-1:0] s);
        logic [W-1:0] res;
        int x, y, nr, nc;
        res = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                x  = (c + 3) % 5;
                y  = (r + 3) % 5;
                nc = (y + 2) % 5;
                nr = ((2 * x + 3 * y) % 5 + 2) % 5;
                res[nr * 5 + nc] = s[r * 5 + c];
            end
        end
        return res;
    endfunction

    assign map_out = mapSlice(map_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous source read and destination write
    logic [W-1:0] srcMem [SliceCount];
    logic [W-1:0] dstMem [SliceCount];
    logic [W-1:0] rdDataReg = '0;
    always @(posedge clk) begin
        if (rd_en) rdDataReg <= srcMem[rd_addr];
        if (wr_en) dstMem[wr_addr] <= wr_data;
    end
    assign rd_data = rdDataReg;

    // Hand-computed slice pairs
    logic [W-1:0] vecIn  [5] = '{25'h0001000, 25'h0002000, 25'h0000000, 25'h1FFFFFF, 25'h0000001};
    logic [W-1:0] vecOut [5] = '{25'h0001000, 25'h0400000, 25'h0000000, 25'h1FFFFFF, 25'h0000400};

    typedef struct {
        int           addr;
        logic [W-1:0] data;
        int           cycle;
    } wrExp_t;

    wrExp_t wrQ[$];
    int     doneQ[$];
    int     checks     = 0;
    int     errors     = 0;
    int     doneCount  = 0;
    int     writeCount = 0;
    wrExp_t expW;
    int     expD;
    int     s;
    int     doneBefore;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportUnexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or signals done
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                writeCount++;
                if (wrQ.size() == 0) begin
                    reportUnexpected("unexpectedWrite");
                end else begin
                    expW = wrQ.pop_front();
                    checkOutput("wrAddr", 64'(wr_addr), 64'(expW.addr));
                    checkOutput("wrData", 64'(wr_data), 64'(expW.data));
                    checkOutput("wrCycle", 64'(cyc), 64'(expW.cycle));
                end
            end
            if (done) begin
                doneCount++;
                if (doneQ.size() == 0) begin
                    reportUnexpected("unexpectedDone");
                end else begin
                    expD = doneQ.pop_front();
                    checkOutput("doneCycle", 64'(cyc), 64'(expD));
                end
            end
        end
    end

    task automatic loadSource(input int offset);
        for (int a = 0; a < SliceCount; a++) srcMem[a] = vecIn[(a + offset) % 5];
    endtask

    task automatic expectPass(input int offset, input int startCyc);
        wrExp_t e;
        for (int k = 0; k < SliceCount; k++) begin
            e.addr  = k;
            e.data  = vecOut[(k + offset) % 5];
            e.cycle = startCyc + k + 3;
            wrQ.push_back(e);
        end
        doneQ.push_back(startCyc + SliceCount + 3);
    endtask

    task automatic waitCycle(input int base, input int n);
        while (cyc < base + n) @(negedge clk);
    endtask

    // Issues a one-cycle start pulse; startCyc is cycle 0 of the pass
    task automatic applyStimulus(input int offset, output int startCyc);
        loadSource(offset);
        @(negedge clk);
        startCyc   = cyc;
        expectPass(offset, startCyc);
        writeCount = 0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finishPass(input int startCyc);
        waitCycle(startCyc, 67);
        checkOutput("readyLowAtDone", 64'(ready), 64'(1'b0));
        waitCycle(startCyc, 68);
        checkOutput("readyBack", 64'(ready), 64'(1'b1));
        checkOutput("writeCount", 64'(writeCount), 64'(SliceCount));
        checkOutput("writesPending", 64'(wrQ.size()), 64'(0));
        checkOutput("donePending", 64'(doneQ.size()), 64'(0));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetReady", 64'(ready), 64'(1'b1));
        checkOutput("resetMapIn", 64'(map_in), 64'(0));
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("idleReady", 64'(ready), 64'(1'b1));
        checkOutput("idleDone", 64'(done), 64'(1'b0));
        checkOutput("idleRdEn", 64'(rd_en), 64'(1'b0));
        checkOutput("idleWrEn", 64'(wr_en), 64'(1'b0));

        // Single-bit slices
        applyStimulus(0, s);
        finishPass(s);
        checkOutput("dst0", 64'(dstMem[0]), 64'(25'h0001000));
        checkOutput("dst1", 64'(dstMem[1]), 64'(25'h0400000));

        // All-zeros and all-ones slices at the bottom addresses
        applyStimulus(2, s);
        finishPass(s);
        checkOutput("dstZeros", 64'(dstMem[0]), 64'(25'h0000000));
        checkOutput("dstOnes", 64'(dstMem[1]), 64'(25'h1FFFFFF));

        // Start pulses during an active pass are ignored
        applyStimulus(4, s);
        waitCycle(s, 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitCycle(s, 66);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finishPass(s);
        doneBefore = doneCount;
        repeat (80) @(negedge clk);
        checkOutput("noRestart", 64'(doneCount), 64'(doneBefore));

        // Reset in the middle of a pass
        applyStimulus(1, s);
        waitCycle(s, 29);
        @(posedge clk);
        #2;
        checkOutput("midPassRdEn", 64'(rd_en), 64'(1'b1));
        checkOutput("midPassWrEn", 64'(wr_en), 64'(1'b1));
        doneBefore = doneCount;
        rst = 1'b1;
        #1;
        checkOutput("abortRdEn", 64'(rd_en), 64'(1'b0));
        checkOutput("abortWrEn", 64'(wr_en), 64'(1'b0));
        checkOutput("abortReady", 64'(ready), 64'(1'b1));
        wrQ.delete();
        doneQ.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("noDoneAfterReset", 64'(doneCount), 64'(doneBefore));
        applyStimulus(3, s);
        finishPass(s);

        // Back-to-back passes with start held high
        loadSource(0);
        @(negedge clk);
        s = cyc;
        expectPass(0, s);
        expectPass(0, s + 68);
        writeCount = 0;
        start      = 1'b1;
        waitCycle(s, 100);
        start = 1'b0;
        waitCycle(s, 136);
        checkOutput("b2bReady", 64'(ready), 64'(1'b1));
        checkOutput("b2bWriteCount", 64'(writeCount), 64'(2 * SliceCount));
        checkOutput("b2bWritesPending", 64'(wrQ.size()), 64'(0));
        checkOutput("b2bDonePending", 64'(doneQ.size()), 64'(0));
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/slice_sequencer.md
# slice_sequencer

Sequential front/back-end for the combinational slice permutation stage (`Mapper`). Takes a start pulse and reads `SliceCount` slices of `N*M` bits from a synchronous source memory, one per cycle. It registers each slice into the `Mapper`, then writes the permuted slice to a destination memory at the same address. On completion it returns a one-cycle `done` pulse. Sits between the state memory and the `Mapper` stage, with one slice per cycle throughput.

## Interface
Parameters:
- `N`, 5, slice rows
- `M`, 5, slice columns
- `SliceCount`, 64, slices per pass
- `AddrWidth`, 6, address width; must satisfy `2**AddrWidth >= SliceCount`

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset, asynchronous, active-high
- `start`  input  1  begin a pass; sampled only in IDLE
- `ready`  output  1  high when in IDLE
- `done`  output  1  one-cycle pulse after the last write
- `rd_en`  output  1  source memory read enable
- `rd_addr`  output  AddrWidth  source read address
- `rd_data`  input  N*M  source data, valid the cycle after `rd_en`
- `map_in`  output  N*M  registered slice driven into the `Mapper`
- `map_out`  input  N*M  permuted slice returned from the `Mapper` (combinational)
- `wr_en`  output  1  destination write enable
- `wr_addr`  output  AddrWidth  destination write address
- `wr_data`  output  N*M  equals `map_out` whenever `wr_en`=1

## Operation
- FSM states:
  - IDLE: `ready`=1. If `start`=1, go to READ with the read counter at 0.
  - READ: `rd_en`=1, `rd_addr`=counter. Counter increments each cycle. After issuing address `SliceCount-1`, go to DRAIN.
  - DRAIN: 2 cycles. No reads. Lets the last two slices leave the pipeline. Then go to DONE.
  - DONE: `done`=1 for 1 cycle, then go to IDLE.
- Pipeline, 3 stages, all valid bits reset to 0:
  - Stage 1: the read issue.
  - Stage 2: `rd_data` return, with `v1` and `a1` (address) delayed.
  - Stage 3: `slice_q` (drives `map_in`), with `v2` and `a2`.
- `wr_en`=`v2`, `wr_addr`=`a2`, `wr_data`=`map_out`.
- Addresses are never wrapped. The counter stops at `SliceCount-1`. No address outside 0..SliceCount-1 is ever issued or written.
- `start` outside IDLE is ignored, including in DONE. A `start` held high in IDLE after DONE launches a new pass.
- Reset values: `ready`=1 and every other output 0. State IDLE, counter 0, `slice_q` 0, valid bits 0.
- Reset mid-pass aborts immediately. No further `rd_en`/`wr_en`, no `done`. Partial destination contents are undefined.

## Timing
- `start` sampled at cycle 0 edge gives READ during cycles 1..SliceCount.
- Address k:
  - read at cycle k+1
  - `rd_data` valid in cycle k+2, captured at its end
  - `wr_en` in cycle k+3 with `wr_addr`=k
- With SliceCount=64:
  - writes occupy cycles 3..66, contiguous, ascending
  - DRAIN occupies cycles 65..66
  - `done` in cycle 67
  - `ready` high again in cycle 68
- Total latency from `start` to `done` is SliceCount+3 cycles.
- `ready` is low from cycle 1 through cycle 67.
- `rd_en` and `wr_en` overlap during cycles 3..64.

## Structure
- Shared package:
  - state encoding (IDLE, READ, DRAIN, DONE as 2-bit localparams)
  - default `N`/`M`/`SliceCount`/`AddrWidth` constants, also used by the `Mapper` bench
- `Mapper` is not instantiated inside. The `map_in`/`map_out` ports connect at the top level.
- One natural sub-module: `slice_pipe_reg`. It holds the parameterised valid/address/data register stage and is instantiated twice (stages 2 and 3).

## Test plan
- Bench setup: the real `Mapper` wired between `map_in`/`map_out`, with `N`=`M`=5.
- Reset-and-idle: assert `rst`, then hold `start`=0 for 10 cycles. Require `ready`=1, with `done`, `rd_en` and `wr_en` all 0.
- Full pass, single-bit slices:
  - Source addr 0 = 25'h0001000. Require destination addr 0 = 25'h0001000.
  - Source addr 1 = 25'h0002000. Require destination addr 1 = 25'h0400000.
- Full pass, all-zeros and all-ones slices:
  - 25'h0000000 → 25'h0000000
  - 25'h1FFFFFF → 25'h1FFFFFF
  - Additionally require exactly 64 writes, addresses 0..63 in order, and `done` exactly at cycle 67.
- `start` pulsed at cycles 10 and 66 of an active pass: require no restart and a single `done` at cycle 67.
- `rst` asserted at cycle 30 of a pass:
  - `rd_en`/`wr_en` drop asynchronously, and no `done` follows.
  - A new `start` after reset completes a clean 64-write pass.
- Back-to-back: `start` held high continuously. Require a new pass to begin the cycle after `ready` returns, giving `done` pulses 68 cycles apart.
